frame_update_sched: RTL and testbench
=====================================

# frame_update_sched

Scheduler for the 16x12 frame tracker. It steps the tracker through the grid one cell per scan slot, gives the object-detection logic time to settle at each cell, and commits each cell update. Every changed cell is forwarded to the display writer over a req/ack handshake. The block sits between the game-tick logic, the frame tracker and the display draw engine, and owns the tracker's `enable` and `sync` inputs.

## Interface
- `COLS`, default 16: grid width in cells.
- `ROWS`, default 12: grid height in cells.
- `SETTLE`, default 2, legal range 1..15: wait cycles at each cell before sampling.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `tick`  in  1  one-cycle pulse that starts a frame scan
- `redraw`  in  1  one-cycle pulse requesting a full redraw; latched as pending
- `clr_status`  in  1  clears `overrun`
- `cell_x`, `cell_y`  in  4 each  tracker's current coordinates
- `cell_diff`  in  1  tracker reports that the current cell changed
- `cell_code`  in  3  tracker's new object code for the current cell
- `trk_enable`  out  1  commits the current cell and advances the tracker
- `trk_sync`  out  1  clears the tracker frame and sets its coordinates to (0,0)
- `draw_req`  out  1  draw request to the display writer
- `draw_x`, `draw_y`  out  4 each  coordinates of the cell to draw
- `draw_code`  out  3  object code to draw
- `draw_ack`  in  1  display writer has accepted the request
- `busy`  out  1  state is not IDLE
- `frame_done`  out  1  one-cycle pulse at the end of a scan
- `dirty_count`  out  8  number of draws issued in the last or current frame
- `overrun`  out  1  sticky flag: a `tick` arrived while `busy`

## Operation
- The FSM has states IDLE, CLEAR, SETTLE, SAMPLE, WAIT_ACK and DONE. `trk_enable`, `trk_sync`, `busy` and `frame_done` are Moore outputs decoded from the state.
- **IDLE**
  - On `tick` with redraw pending: go to CLEAR.
  - On `tick` otherwise: go to SETTLE.
  - Either way, clear `dirty_count` and load the settle counter with `SETTLE`.
- **CLEAR**
  - `trk_sync` is 1 for exactly one cycle.
  - Redraw pending is cleared.
  - Next state is SETTLE.
- **SETTLE**
  - The settle counter decrements each cycle.
  - At 1, go to SAMPLE.
- **SAMPLE**
  - `trk_enable` is 1 for exactly one cycle.
  - If `cell_diff`=1: register `cell_x`/`cell_y`/`cell_code` into `draw_x`/`draw_y`/`draw_code`, set `draw_req`, increment `dirty_count` (saturating at 255), and record whether this cell is the last cell. Next state is WAIT_ACK.
  - Else, if (`cell_x`,`cell_y`) = (`COLS`-1,`ROWS`-1): go to DONE.
  - Else: go to SETTLE with the counter reloaded.
- **WAIT_ACK**
  - `draw_req` and the draw fields hold stable.
  - When `draw_ack`=1 is sampled: clear `draw_req` at the next edge, then go to DONE if the last-cell flag is set, else go to SETTLE.
- **DONE**
  - `frame_done` is 1 for one cycle.
  - Next state is IDLE.
  - `dirty_count` holds until the next accepted `tick`.
- `trk_enable` and `trk_sync` are never both 1 in the same cycle.
- The scan relies on the tracker wrapping to (0,0) after the last cell's commit. The tracker is reset from the same reset source, so every scan starts at (0,0).
- `tick` while `busy`: the tick is dropped and `overrun` is set; it stays set until `clr_status` or `rst`. If `tick` and `clr_status` arrive in the same cycle while busy, set wins.
- `redraw` in any state sets redraw pending. The pending redraw is consumed only by the next accepted `tick`.
- `draw_ack` is ignored while `draw_req`=0.

## Timing
- Reset values: state IDLE; all outputs 0; redraw pending 0; settle counter 0.
- Reset is asynchronous. Asserting it mid-scan drops `draw_req` immediately; the frame is abandoned and no `frame_done` is issued.
- `tick` is sampled at cycle 0. The first SAMPLE is at cycle `SETTLE`+1, or `SETTLE`+2 when CLEAR runs.
- Each cell with no diff takes `SETTLE`+1 cycles.
- Each diff cell adds the WAIT_ACK dwell, minimum 1 cycle (ack already high in the first WAIT_ACK cycle).
- A frame with no diffs and `SETTLE`=2 runs SAMPLE at cycles 3, 6, ..., 576. `frame_done` is high at cycle 577 and `busy` is 0 from cycle 578.

## Structure
- Shared package `frame_pkg` holds:
  - `COLS` and `ROWS` constants.
  - `obj_code_t` enum: EMPTY=000, HEAD=001, BODY=010, APPLE=011, BORDER=100.
  - `sched_state_t` enum.
- Single module with no sub-modules. The settle counter and draw register are local.

## Test plan
- `SETTLE`=2, `tick` at cycle 0, `cell_diff` held at 0: 192 `trk_enable` pulses at cycles 3+3k; `frame_done` at 577; `dirty_count`=0; `trk_sync` never asserted.
- `cell_diff`=1 only at (5,3) with `cell_code`=010, `draw_ack` 4 cycles after `draw_req` rises: `draw_req` holds x=5, y=3, code=2 until ack; exactly one `trk_enable` at that cell; `dirty_count`=1; `frame_done` is delayed by the ack wait.
- `redraw` then `tick`: `trk_sync`=1 at cycle 1 only; first `trk_enable` at cycle 4; never coincident with `trk_sync`; pending cleared. A second `tick` produces no `trk_sync`.
- `tick` mid-scan: `overrun`=1 and the scan completes unchanged; `clr_status` returns `overrun` to 0.
- Diff at (15,11) with `draw_ack` tied to 1: `draw_req` high for 1 cycle, then DONE; `frame_done` pulses once; next scan's first sample is at (0,0).
- `rst` asserted during WAIT_ACK: `draw_req`=0 and `busy`=0 immediately; after release, `tick` starts a normal scan with `dirty_count` cleared.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and grid constants for the frame tracker and its update scheduler.
package frame_pkg;

    localparam int COLS = 16;
    localparam int ROWS = 12;

    typedef enum logic [2:0] {
        EMPTY  = 3'b000,
        HEAD   = 3'b001,
        BODY   = 3'b010,
        APPLE  = 3'b011,
        BORDER = 3'b100
    } obj_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT_ACK,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/frame_update_sched.sv
// Walks the frame tracker one cell per scan slot, lets detection settle, commits
// each cell and forwards changed cells to the display writer over req/ack.
module frame_update_sched
    import frame_pkg::*;
#(
    parameter int COLS   = frame_pkg::COLS,
    parameter int ROWS   = frame_pkg::ROWS,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       redraw,
    input  logic       clr_status,
    input  logic [3:0] cell_x,
    input  logic [3:0] cell_y,
    input  logic       cell_diff,
    input  logic [2:0] cell_code,
    output logic       trk_enable,
    output logic       trk_sync,
    output logic       draw_req,
    output logic [3:0] draw_x,
    output logic [3:0] draw_y,
    output logic [2:0] draw_code,
    input  logic       draw_ack,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] dirty_count,
    output logic       overrun
);

    localparam logic [3:0] LAST_X    = 4'(COLS - 1);
    localparam logic [3:0] LAST_Y    = 4'(ROWS - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    sched_state_t state;
    logic [3:0]   settle_cnt;
    logic         redraw_pend;
    logic         last_cell;
    logic         at_last;

    assign at_last = (cell_x == LAST_X) && (cell_y == LAST_Y);

    // Moore outputs are registered alongside the state transition that enters their state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            last_cell   <= 1'b0;
            trk_enable  <= 1'b0;
            trk_sync    <= 1'b0;
            draw_req    <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_code   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            dirty_count <= '0;
        end else begin
            trk_enable <= 1'b0;
            trk_sync   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        dirty_count <= '0;
                        settle_cnt  <= SETTLE_LD;
                        busy        <= 1'b1;
                        if (redraw_pend) begin
                            state    <= ST_CLEAR;
                            trk_sync <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_CLEAR: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state      <= ST_SAMPLE;
                        trk_enable <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    settle_cnt <= SETTLE_LD;
                    if (cell_diff) begin
                        state     <= ST_WAIT_ACK;
                        draw_req  <= 1'b1;
                        draw_x    <= cell_x;
                        draw_y    <= cell_y;
                        draw_code <= cell_code;
                        last_cell <= at_last;
                        if (dirty_count != 8'hFF)
                            dirty_count <= dirty_count + 8'd1;
                    end else if (at_last) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state      <= ST_SETTLE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (draw_ack) begin
                        draw_req <= 1'b0;
                        if (last_cell) begin
                            state      <= ST_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A redraw landing in the CLEAR cycle is a fresh request and must survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            redraw_pend <= 1'b0;
        else if (redraw)
            redraw_pend <= 1'b1;
        else if (state == ST_CLEAR)
            redraw_pend <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= 1'b0;
        else if (tick && busy)
            overrun <= 1'b1;
        else if (clr_status)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_frame_update_sched.sv
// Random-map scan checks against a cell-list timing model of the scheduler.
module tb_frame_update_sched;

    localparam int S  = 2;
    localparam int NC = 192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, redraw = 1'b0, clr_status = 1'b0, draw_ack = 1'b0;
    logic [3:0] cell_x, cell_y;
    logic       cell_diff;
    logic [2:0] cell_code;
    logic       trk_enable, trk_sync, draw_req, busy, frame_done, overrun;
    logic [3:0] draw_x, draw_y;
    logic [2:0] draw_code;
    logic [7:0] dirty_count;

    int total = 0, bad = 0, cyc = 0;

    bit         diff_map[NC];
    logic [2:0] code_map[NC];
    int         ack_dly[NC];
    bit         ack_tie = 0, ack_noise = 0, pend_model = 0;

    logic [3:0] tx, ty;
    int         cur_idx;

    frame_update_sched #(.COLS(16), .ROWS(12), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .tick(tick), .redraw(redraw), .clr_status(clr_status),
        .cell_x(cell_x), .cell_y(cell_y), .cell_diff(cell_diff), .cell_code(cell_code),
        .trk_enable(trk_enable), .trk_sync(trk_sync), .draw_req(draw_req),
        .draw_x(draw_x), .draw_y(draw_y), .draw_code(draw_code), .draw_ack(draw_ack),
        .busy(busy), .frame_done(frame_done), .dirty_count(dirty_count), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tracker stand-in: raster walk with wrap, cleared by sync or reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx <= 4'd0; ty <= 4'd0;
        end else if (trk_sync) begin
            tx <= 4'd0; ty <= 4'd0;
        end else if (trk_enable) begin
            if (tx == 4'd15) begin
                tx <= 4'd0;
                ty <= (ty == 4'd11) ? 4'd0 : ty + 4'd1;
            end else begin
                tx <= tx + 4'd1;
            end
        end
    end

    always_comb cur_idx = int'(ty) * 16 + int'(tx);
    assign cell_x    = tx;
    assign cell_y    = ty;
    assign cell_diff = diff_map[cur_idx];
    assign cell_code = code_map[cur_idx];

    // Display-writer stand-in.
    int ack_cnt = 0;
    always @(negedge clk) begin
        if (ack_tie) begin
            draw_ack = 1'b1;
        end else if (draw_req === 1'b1) begin
            draw_ack = (ack_cnt >= ack_dly[int'(draw_y) * 16 + int'(draw_x)]);
            ack_cnt++;
        end else begin
            ack_cnt  = 0;
            draw_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Observed event log.
    int         en_q[$], sync_q[$], done_q[$], dr_cyc[$];
    logic [10:0] dr_fld[$];
    int         last_busy = -1, both_cnt = 0, req_hi = 0;
    logic       prev_req = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (trk_enable) en_q.push_back(cyc);
            if (trk_sync) sync_q.push_back(cyc);
            if (trk_enable && trk_sync) both_cnt++;
            if (frame_done) done_q.push_back(cyc);
            if (busy) last_busy = cyc;
            if (draw_req) req_hi++;
            if (draw_req && !prev_req) begin
                dr_cyc.push_back(cyc);
                dr_fld.push_back({draw_x, draw_y, draw_code});
            end
            prev_req = draw_req;
        end else begin
            prev_req = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        en_q.delete(); sync_q.delete(); done_q.delete(); dr_cyc.delete(); dr_fld.delete();
        last_busy = -1; both_cnt = 0; req_hi = 0;
    endtask

    task automatic clear_maps();
        for (int i = 0; i < NC; i++) begin
            diff_map[i] = 0; code_map[i] = 3'd0; ack_dly[i] = 0;
        end
    endtask

    task automatic set_cell(input int x, input int y, input int code, input int dly);
        diff_map[y * 16 + x] = 1;
        code_map[y * 16 + x] = 3'(code);
        ack_dly[y * 16 + x]  = dly;
    endtask

    task automatic rand_maps();
        for (int i = 0; i < NC; i++) begin
            diff_map[i] = ($urandom_range(0, 7) == 0);
            code_map[i] = 3'($urandom_range(0, 4));
            ack_dly[i]  = $urandom_range(0, 3);
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0) begin redraw = 1'b1; pend_model = 1; end
        else clr_status = 1'b1;
        @(negedge clk);
        redraw = 1'b0; clr_status = 1'b0;
    endtask

    // Runs one scan; optional extra tick (with clr_status) and redraw at offsets from the start tick.
    task automatic run_frame(input string name, input int xtick_off, input bit xclr, input int redraw_off);
        int t0, t, nd, e_done, e_req;
        bit sync;
        int  e_en[$], e_dc[$];
        logic [10:0] e_df[$];
        clear_log();
        sync = pend_model;
        pend_model = 0;
        @(negedge clk);
        t0 = cyc; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;

        t = t0 + (sync ? 1 : 0); nd = 0; e_req = 0;
        for (int i = 0; i < NC; i++) begin
            t += S + 1;
            e_en.push_back(t);
            if (diff_map[i]) begin
                e_dc.push_back(t + 1);
                e_df.push_back({4'(i % 16), 4'(i / 16), code_map[i]});
                t += (ack_tie ? 0 : ack_dly[i]) + 1;
                e_req += (ack_tie ? 0 : ack_dly[i]) + 1;
                nd++;
            end
        end
        e_done = t + 1;

        for (int k = 0; k < 4000 && done_q.size() == 0; k++) begin
            if (cyc == t0 + xtick_off) begin tick = 1'b1; clr_status = xclr; end
            if (cyc == t0 + redraw_off) begin redraw = 1'b1; pend_model = 1; end
            @(negedge clk);
            tick = 1'b0; clr_status = 1'b0; redraw = 1'b0;
        end
        repeat (3) @(negedge clk);

        chk({name, " done_count"}, done_q.size(), 1);
        chk({name, " done_cyc"}, (done_q.size() > 0) ? done_q[0] - t0 : -1, e_done - t0);
        chk({name, " busy_end"}, last_busy - t0, e_done - t0);
        chk({name, " en_count"}, en_q.size(), NC);
        for (int i = 0; i < en_q.size() && i < NC; i++)
            chk($sformatf("%s en_cyc[%0d]", name, i), en_q[i] - t0, e_en[i] - t0);
        chk({name, " draw_count"}, dr_cyc.size(), e_dc.size());
        for (int i = 0; i < dr_cyc.size() && i < e_dc.size(); i++) begin
            chk($sformatf("%s draw_cyc[%0d]", name, i), dr_cyc[i] - t0, e_dc[i] - t0);
            chk($sformatf("%s draw_fld[%0d]", name, i), dr_fld[i], e_df[i]);
        end
        chk({name, " req_cycles"}, req_hi, e_req);
        chk({name, " sync_count"}, sync_q.size(), sync ? 1 : 0);
        if (sync_q.size() > 0)
            chk({name, " sync_cyc"}, sync_q[0] - t0, 1);
        chk({name, " en_sync_overlap"}, both_cnt, 0);
        chk({name, " dirty"}, dirty_count, (nd > 255) ? 255 : nd);
    endtask

    initial begin
        clear_maps();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {trk_enable, trk_sync, draw_req, draw_x, draw_y, draw_code,
                              busy, frame_done, dirty_count, overrun}, 0);
        rst = 1'b0;

        run_frame("quiet", -1, 0, -1);
        chk("quiet overrun", overrun, 0);

        clear_maps(); set_cell(5, 3, 2, 4);
        run_frame("one_diff", -1, 0, -1);

        clear_maps(); pulse(0);
        run_frame("redraw", -1, 0, -1);
        run_frame("after_redraw", -1, 0, -1);

        rand_maps();
        run_frame("overrun", 40, 0, -1);
        chk("overrun set", overrun, 1);
        pulse(1);
        chk("overrun cleared", overrun, 0);
        run_frame("overrun_clr_race", 100, 1, 150);
        chk("overrun set_wins", overrun, 1);
        pulse(1);
        run_frame("pending_from_scan", -1, 0, -1);

        ack_noise = 1;
        for (int f = 0; f < 3; f++) begin
            rand_maps();
            if ($urandom_range(0, 1) == 1) pulse(0);
            run_frame($sformatf("rand%0d", f), -1, 0, -1);
        end
        ack_noise = 0;

        clear_maps(); set_cell(15, 11, 4, 0); ack_tie = 1;
        run_frame("last_cell", -1, 0, -1);
        clear_maps(); set_cell(0, 0, 1, 0);
        run_frame("wrap_origin", -1, 0, -1);
        ack_tie = 0;

        clear_maps(); set_cell(4, 1, 3, 100000);
        clear_log();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        for (int k = 0; k < 300 && draw_req !== 1'b1; k++) @(negedge clk);
        chk("rst_test req_up", draw_req, 1);
        chk("rst_test dirty_before", dirty_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_test req_drop", draw_req, 0);
        chk("rst_test busy_drop", busy, 0);
        chk("rst_test dirty_clr", dirty_count, 0);
        pend_model = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_test no_done", done_q.size(), 0);
        ack_dly[1 * 16 + 4] = 1;
        run_frame("after_rst", -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
